input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
Conditions the raw board inputs (push-buttons and slide switches) before they reach the computer's input ports or the board-level control selects. It is the input-side counterpart of the LED and seven-segment output path. Each bit passes through a two-flop synchronizer and a per-bit stable-count filter clocked by an internal sample tick. The block presents debounced levels, one-cycle rise/fall event pulses, and a sticky "changed" flag that software can poll and clear.

Parameters:
WIDTH, 20, number of input bits (4 buttons + 16 switches)
TICK_DIV, 250000, clk cycles per sample tick (25 MHz -> 100 Hz); legal range >= 1
STABLE_CNT, 4, consecutive differing samples required to accept a new level; legal range >= 1
RESET_VAL, 0 (WIDTH bits), value loaded into stable on reset

Ports:
clk  input  1  block clock; all state is on its rising edge
reset  input  1  asynchronous, active-high reset
raw  input  WIDTH  unsynchronized board inputs
clr  input  1  synchronous clear of the changed flag
stable  output  WIDTH  debounced level
rise  output  WIDTH  one-cycle pulse per bit on an accepted 0->1
fall  output  WIDTH  one-cycle pulse per bit on an accepted 1->0
changed  output  1  sticky flag: some stable bit flipped since the last clr
tick  output  1  sample strobe, high one clk per TICK_DIV cycles

Behaviour:
- Reset (async, active-high) forces: sync stages 0; prescaler 0; all per-bit counters 0; stable = RESET_VAL; rise = 0; fall = 0; changed = 0. Reset may arrive mid-count and discards any partial count.
- Synchronizer: sync = raw delayed by two clk flops. It has no filtering.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. tick is combinational (prescaler == TICK_DIV-1). With TICK_DIV=1, tick is held high constantly.
- Per-bit filter: counter width is clog2(STABLE_CNT+1). Filter state updates only at edges where tick=1. At such an edge, for each bit i:
  - sync[i] == stable[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i] == STABLE_CNT-1: stable[i] <= sync[i]; cnt[i] <= 0; rise[i] <= sync[i]; fall[i] <= ~sync[i].
  - Otherwise: cnt[i] <= cnt[i]+1.
- Acceptance rule: a new level needs STABLE_CNT consecutive ticks at which sync differs from stable. One matching tick restarts the count. Pulses shorter than STABLE_CNT ticks are fully rejected.
- rise/fall: registered. High for exactly the one clk following the accepting edge, 0 on all other cycles. rise[i] and fall[i] are never high together.
- Latency: raw change to stable change is 2 clk of synchronization, plus the wait to the next tick, plus (STABLE_CNT-1)*TICK_DIV clk. stable, rise and changed update at the same edge.
- Bit independence: bits filter independently. Several bits may flip on the same tick, raising multiple rise/fall bits together.
- changed flag:
  - Set at any edge where at least one stable bit flips.
  - Cleared at an edge with clr=1.
  - If clr=1 and a flip happen at the same edge, set wins and changed stays 1.
  - clr while no flip occurs: changed = 0 from the next cycle.
- No combinational path from raw to any output.

Test Plan:
- Params WIDTH=4, TICK_DIV=4, STABLE_CNT=3. Release reset and run 12 clk -> tick high exactly on cycles 3, 7, 11 after reset; stable=0, changed=0, rise=fall=0.
- Set raw[0]=1 and hold -> stable[0] rises at the 3rd tick after sync[0]=1. rise[0]=1 for one clk at the same time; changed=1; fall stays 0.
- From stable[0]=1, pulse raw[0]=0 long enough to be sampled by exactly 2 ticks, then return to 1 -> stable[0] stays 1, no fall pulse, cnt[0] returns to 0 at the next tick.
- Drive raw=4'b1010 from stable=0 -> at the accepting edge stable=4'b1010, rise=4'b1010 for one clk, fall=0.
- Assert clr on the same edge a bit flips -> changed remains 1. Assert clr on a later quiet edge -> changed=0 on the following cycle.
- Hold raw[1] differing for 2 ticks, then assert reset for 1 clk, then keep raw[1] held -> immediately after reset stable=RESET_VAL and outputs are 0. The flip needs 3 fresh ticks after reset, not 1.

Source files
------------

// File: rtl/input_debouncer_if.sv
// Signal bundle between the raw board inputs, software-visible status and the debouncer.
// The debouncer takes the slave side; whoever drives raw/clr takes the master side.
interface input_debouncer_if #(
    parameter int WIDTH = 20
);
    logic [WIDTH-1:0] raw;
    logic             clr;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;
    logic             tick;

    modport master (
        output raw,
        output clr,
        input  stable,
        input  rise,
        input  fall,
        input  changed,
        input  tick
    );

    modport slave (
        input  raw,
        input  clr,
        output stable,
        output rise,
        output fall,
        output changed,
        output tick
    );
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus per-bit stable-count filter for buttons and switches.
// Produces debounced levels, one-cycle edge pulses and a sticky software-clearable change flag.
module input_debouncer #(
    parameter int               WIDTH      = 20,
    parameter int               TICK_DIV   = 250000,
    parameter int               STABLE_CNT = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input_debouncer_if.slave  bus
);
    localparam int               CNT_W    = $clog2(STABLE_CNT + 1);
    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [WIDTH-1:0] r_sync_meta;
    logic [WIDTH-1:0] r_sync;
    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_changed;

    logic             w_tick;
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_accept;

    // With TICK_DIV == 1 the prescaler stays at 0 == PRE_LAST, so the tick is permanently high.
    assign w_tick = (r_pre == PRE_LAST);

    // Two-flop synchronizer on every raw input bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_sync_meta <= bus.raw;
            r_sync      <= r_sync_meta;
        end
    end

    // Sample-tick prescaler counting 0..TICK_DIV-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Per-bit next-count and acceptance decision; a single matching sample restarts the count.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_tick) begin
                if (r_sync[i] == r_stable[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    w_cnt_nxt[i] = '0;
                    w_accept[i]  = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end else begin
                w_cnt_nxt[i] = r_cnt[i];
            end
        end
    end

    // Filter state, debounced level and the one-cycle edge pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '{default: '0};
            r_stable <= RESET_VAL;
            r_rise   <= '0;
            r_fall   <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_stable <= r_stable ^ w_accept;
            r_rise   <= w_accept & r_sync;
            r_fall   <= w_accept & ~r_sync;
        end
    end

    // Sticky change flag; a flip on the same edge as clr keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_changed <= 1'b0;
        end else if (|w_accept) begin
            r_changed <= 1'b1;
        end else if (bus.clr) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= r_changed;
        end
    end

    assign bus.stable  = r_stable;
    assign bus.rise    = r_rise;
    assign bus.fall    = r_fall;
    assign bus.changed = r_changed;
    assign bus.tick    = w_tick;
endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with WIDTH=4, TICK_DIV=4, STABLE_CNT=3.
// Cycle c counts rising edges since reset release; outputs are sampled on the falling edge.
module tb_input_debouncer;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   cyc;

    input_debouncer_if #(.WIDTH(4)) bus ();

    input_debouncer #(
        .WIDTH      (4),
        .TICK_DIV   (4),
        .STABLE_CNT (3),
        .RESET_VAL  (4'b0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset;
        logic exp_tick;
        @(negedge clk);
        n_vec++;
        if ({bus.stable, bus.rise, bus.fall, bus.changed, bus.tick} !== 14'b0) begin
            n_err++;
            $display("FAIL in_reset got st=%b r=%b f=%b ch=%b t=%b required all 0",
                     bus.stable, bus.rise, bus.fall, bus.changed, bus.tick);
        end
        reset = 1'b0;
        cyc   = 0;
        for (int c = 0; c <= 12; c++) begin
            exp_tick = ((c % 4) == 3) ? 1'b1 : 1'b0;
            n_vec++;
            if (bus.tick !== exp_tick) begin
                n_err++;
                $display("FAIL tick_phase cyc=%0d got=%b required=%b", c, bus.tick, exp_tick);
            end
            n_vec++;
            if ({bus.stable, bus.rise, bus.fall, bus.changed} !== 13'b0) begin
                n_err++;
                $display("FAIL idle_outputs cyc=%0d got st=%b r=%b f=%b ch=%b required 0",
                         c, bus.stable, bus.rise, bus.fall, bus.changed);
            end
            step();
        end
    endtask

    // raw[0] 0->1 at cycle 0: sync visible from cycle 2, ticks 3,7,11 accept, new level in cycle 12.
    task automatic test_rise;
        logic [3:0] exp_st;
        logic [3:0] exp_r;
        logic       exp_ch;
        bus.raw = 4'b0000;
        bus.clr = 1'b0;
        do_reset();
        bus.raw = 4'b0001;
        for (int c = 0; c <= 13; c++) begin
            exp_st = (c >= 12) ? 4'b0001 : 4'b0000;
            exp_r  = (c == 12) ? 4'b0001 : 4'b0000;
            exp_ch = (c >= 12) ? 1'b1 : 1'b0;
            n_vec++;
            if ({bus.stable, bus.rise, bus.fall, bus.changed} !== {exp_st, exp_r, 4'b0000, exp_ch}) begin
                n_err++;
                $display("FAIL rise0 cyc=%0d got st=%b r=%b f=%b ch=%b required st=%b r=%b f=0000 ch=%b",
                         c, bus.stable, bus.rise, bus.fall, bus.changed, exp_st, exp_r, exp_ch);
            end
            step();
        end
    endtask

    // Two glitches each seen by exactly 2 ticks (19,23 and 31,35) separated by a matching tick 27.
    task automatic test_glitch_reject;
        for (int c = 14; c <= 42; c++) begin
            bus.raw[0] = ((c >= 15 && c <= 22) || (c >= 27 && c <= 34)) ? 1'b0 : 1'b1;
            n_vec++;
            if ({bus.stable, bus.rise, bus.fall, bus.changed} !== {4'b0001, 4'b0000, 4'b0000, 1'b1}) begin
                n_err++;
                $display("FAIL glitch cyc=%0d got st=%b r=%b f=%b ch=%b required st=0001 r=0000 f=0000 ch=1",
                         c, bus.stable, bus.rise, bus.fall, bus.changed);
            end
            step();
        end
    endtask

    task automatic test_multi_bit;
        logic [3:0] exp_st;
        logic [3:0] exp_r;
        logic       exp_ch;
        bus.raw = 4'b0000;
        bus.clr = 1'b0;
        do_reset();
        bus.raw = 4'b1010;
        for (int c = 0; c <= 13; c++) begin
            exp_st = (c >= 12) ? 4'b1010 : 4'b0000;
            exp_r  = (c == 12) ? 4'b1010 : 4'b0000;
            exp_ch = (c >= 12) ? 1'b1 : 1'b0;
            n_vec++;
            if ({bus.stable, bus.rise, bus.fall, bus.changed} !== {exp_st, exp_r, 4'b0000, exp_ch}) begin
                n_err++;
                $display("FAIL multi cyc=%0d got st=%b r=%b f=%b ch=%b required st=%b r=%b f=0000 ch=%b",
                         c, bus.stable, bus.rise, bus.fall, bus.changed, exp_st, exp_r, exp_ch);
            end
            step();
        end
    endtask

    // raw back to 0 at cycle 14: ticks 19,23,27 accept in cycle 28; clr coincides with that edge,
    // then a quiet clr in cycle 30 drops changed from cycle 31.
    task automatic test_fall_and_clr;
        logic [3:0] exp_st;
        logic [3:0] exp_f;
        logic       exp_ch;
        bus.raw = 4'b0000;
        for (int c = 14; c <= 33; c++) begin
            bus.clr = (c == 27 || c == 30) ? 1'b1 : 1'b0;
            exp_st  = (c >= 28) ? 4'b0000 : 4'b1010;
            exp_f   = (c == 28) ? 4'b1010 : 4'b0000;
            exp_ch  = (c >= 31) ? 1'b0 : 1'b1;
            n_vec++;
            if ({bus.stable, bus.rise, bus.fall, bus.changed} !== {exp_st, 4'b0000, exp_f, exp_ch}) begin
                n_err++;
                $display("FAIL fall_clr cyc=%0d got st=%b r=%b f=%b ch=%b required st=%b r=0000 f=%b ch=%b",
                         c, bus.stable, bus.rise, bus.fall, bus.changed, exp_st, exp_f, exp_ch);
            end
            step();
        end
        bus.clr = 1'b0;
    endtask

    // raw[1] counted by ticks 3,7, then reset; after release the flip needs ticks 3,7,11 again.
    task automatic test_reset_mid_count;
        logic [3:0] exp_st;
        logic [3:0] exp_r;
        bus.raw = 4'b0000;
        bus.clr = 1'b0;
        do_reset();
        bus.raw = 4'b0010;
        for (int c = 0; c <= 7; c++) begin
            n_vec++;
            if (bus.stable !== 4'b0000) begin
                n_err++;
                $display("FAIL pre_reset_hold cyc=%0d got st=%b required 0000", c, bus.stable);
            end
            step();
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({bus.stable, bus.rise, bus.fall, bus.changed} !== 13'b0) begin
            n_err++;
            $display("FAIL mid_reset got st=%b r=%b f=%b ch=%b required all 0",
                     bus.stable, bus.rise, bus.fall, bus.changed);
        end
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        for (int c = 0; c <= 13; c++) begin
            exp_st = (c >= 12) ? 4'b0010 : 4'b0000;
            exp_r  = (c == 12) ? 4'b0010 : 4'b0000;
            n_vec++;
            if ({bus.stable, bus.rise, bus.fall} !== {exp_st, exp_r, 4'b0000}) begin
                n_err++;
                $display("FAIL post_reset cyc=%0d got st=%b r=%b f=%b required st=%b r=%b f=0000",
                         c, bus.stable, bus.rise, bus.fall, exp_st, exp_r);
            end
            step();
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        cyc     = 0;
        reset   = 1'b1;
        bus.raw = 4'b0000;
        bus.clr = 1'b0;
        test_reset();
        test_rise();
        test_glitch_reject();
        test_multi_bit();
        test_fall_and_clr();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
